// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall and forwarding controller for the five-stage pipeline.
//               Keeps shadow copies of destination register / result timing
//               for the E, M and W stages, and from them produces the D-stage
//               stall, the D/E bubble request and every forwarding select.
//               Also owns the multiply/divide busy counter and holds HI/LO
//               users in D while that unit is busy.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               rs_D, rt_D      - source registers of the D instruction
//               tuse_rs_D/rt_D  - cycles until the source is consumed (3=unused)
//               wba_D, tnew_D   - destination and result latency of D instr
//               md_op_D         - 00 none, 01 mult, 10 div, 11 HI/LO access
//               stall, clr_E    - hold F/D, bubble into D/E
//               md_busy         - multiply/divide unit busy
//               fwd_rs_D/rt_D   - 0 GRF, 1 from M, 2 from E
//               fwd_rs_E/rt_E   - 0 pipeline, 1 from W, 2 from M
//               fwd_rt_M        - 0 pipeline, 1 from W
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [1:0] tuse_rs_D,
   input  logic [1:0] tuse_rt_D,
   input  logic [4:0] wba_D,
   input  logic [1:0] tnew_D,
   input  logic [1:0] md_op_D,
   output logic       stall,
   output logic       clr_E,
   output logic       md_busy,
   output logic [1:0] fwd_rs_D,
   output logic [1:0] fwd_rt_D,
   output logic [1:0] fwd_rs_E,
   output logic [1:0] fwd_rt_E,
   output logic       fwd_rt_M
);

   localparam logic [1:0] c_MD_NONE  = 2'b00;
   localparam logic [1:0] c_MD_MULT  = 2'b01;
   localparam logic [1:0] c_MD_DIV   = 2'b10;
   localparam logic [1:0] c_TUSE_NONE = 2'd3;
   localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYC);
   localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYC);

   // Shadow pipeline state
   logic [4:0] r_rs_E, r_rt_E, r_wba_E;
   logic [1:0] r_tnew_E, r_md_E;
   logic [4:0] r_wba_M, r_rt_M;
   logic [1:0] r_tnew_M;
   logic [4:0] r_wba_W;
   logic [3:0] r_md_cnt;

   logic w_stall_rs, w_stall_rt, w_stall_md, w_md_start_E;

   // A source stalls when the producing instruction in E or M still needs
   // more cycles than the consumer can wait. Register 0 never creates hazards.
   always_comb begin
      w_stall_rs = 1'b0;
      w_stall_rt = 1'b0;
      if (rs_D != 5'd0 && tuse_rs_D != c_TUSE_NONE) begin
         w_stall_rs = ((rs_D == r_wba_E) && (tuse_rs_D < r_tnew_E)) ||
                      ((rs_D == r_wba_M) && (tuse_rs_D < r_tnew_M));
      end
      if (rt_D != 5'd0 && tuse_rt_D != c_TUSE_NONE) begin
         w_stall_rt = ((rt_D == r_wba_E) && (tuse_rt_D < r_tnew_E)) ||
                      ((rt_D == r_wba_M) && (tuse_rt_D < r_tnew_M));
      end
   end

   // A start sitting in E counts as busy before the counter has loaded, so a
   // back-to-back md instruction in D is held off.
   assign w_md_start_E = (r_md_E == c_MD_MULT) || (r_md_E == c_MD_DIV);
   assign md_busy      = (r_md_cnt != 4'd0) || w_md_start_E;
   assign w_stall_md   = (md_op_D != c_MD_NONE) && md_busy;

   assign stall = w_stall_rs || w_stall_rt || w_stall_md;
   assign clr_E = stall;

   // Forwarding selects; the younger stage is tested first so it wins.
   always_comb begin
      fwd_rs_D = 2'd0;
      fwd_rt_D = 2'd0;
      fwd_rs_E = 2'd0;
      fwd_rt_E = 2'd0;
      fwd_rt_M = 1'b0;

      if (rs_D != 5'd0) begin
         if (rs_D == r_wba_E && r_tnew_E == 2'd0)      fwd_rs_D = 2'd2;
         else if (rs_D == r_wba_M && r_tnew_M == 2'd0) fwd_rs_D = 2'd1;
      end
      if (rt_D != 5'd0) begin
         if (rt_D == r_wba_E && r_tnew_E == 2'd0)      fwd_rt_D = 2'd2;
         else if (rt_D == r_wba_M && r_tnew_M == 2'd0) fwd_rt_D = 2'd1;
      end
      if (r_rs_E != 5'd0) begin
         if (r_rs_E == r_wba_M && r_tnew_M == 2'd0)    fwd_rs_E = 2'd2;
         else if (r_rs_E == r_wba_W)                   fwd_rs_E = 2'd1;
      end
      if (r_rt_E != 5'd0) begin
         if (r_rt_E == r_wba_M && r_tnew_M == 2'd0)    fwd_rt_E = 2'd2;
         else if (r_rt_E == r_wba_W)                   fwd_rt_E = 2'd1;
      end
      if (r_rt_M != 5'd0 && r_rt_M == r_wba_W)         fwd_rt_M = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rs_E   <= 5'd0;
         r_rt_E   <= 5'd0;
         r_wba_E  <= 5'd0;
         r_tnew_E <= 2'd0;
         r_md_E   <= 2'd0;
         r_wba_M  <= 5'd0;
         r_tnew_M <= 2'd0;
         r_rt_M   <= 5'd0;
         r_wba_W  <= 5'd0;
         r_md_cnt <= 4'd0;
      end else begin
         // E->M->W advances regardless of the stall
         r_wba_M  <= r_wba_E;
         r_tnew_M <= (r_tnew_E == 2'd0) ? 2'd0 : r_tnew_E - 2'd1;
         r_rt_M   <= r_rt_E;
         r_wba_W  <= r_wba_M;

         if (stall) begin
            r_rs_E   <= 5'd0;
            r_rt_E   <= 5'd0;
            r_wba_E  <= 5'd0;
            r_tnew_E <= 2'd0;
            r_md_E   <= 2'd0;
         end else begin
            r_rs_E   <= rs_D;
            r_rt_E   <= rt_D;
            r_wba_E  <= wba_D;
            r_tnew_E <= tnew_D;
            r_md_E   <= md_op_D;
         end

         if (r_md_E == c_MD_MULT)      r_md_cnt <= c_MULT_CNT;
         else if (r_md_E == c_MD_DIV)  r_md_cnt <= c_DIV_CNT;
         else if (r_md_cnt != 4'd0)    r_md_cnt <= r_md_cnt - 4'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed vector table,
//               multi-cycle md/reset sequences and randomized traffic checked
//               against a cycle-indexed instruction-history model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] rs_D = '0, rt_D = '0, wba_D = '0;
   logic [1:0] tuse_rs_D = 2'd3, tuse_rt_D = 2'd3, tnew_D = '0, md_op_D = '0;
   logic       stall, clr_E, md_busy, fwd_rt_M;
   logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

   hazard_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
      .clk(clk), .reset(reset),
      .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
      .wba_D(wba_D), .tnew_D(tnew_D), .md_op_D(md_op_D),
      .stall(stall), .clr_E(clr_E), .md_busy(md_busy),
      .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
      .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // hist[0] entered E this cycle, hist[1] one cycle earlier, hist[2] two.
   typedef struct packed {
      logic [4:0] rs, rt, wba;
      logic [1:0] tnew, md;
   } ins_t;

   ins_t hist[3];
   int   now = 0;
   int   busy_until = -1;

   function automatic int remain(input ins_t x, input int age);
      return (int'(x.tnew) > age) ? int'(x.tnew) - age : 0;
   endfunction

   function automatic bit hz(input logic [4:0] src, input logic [1:0] tuse);
      bit h = 0;
      if (src == 0 || tuse == 2'd3) return 0;
      for (int a = 0; a < 2; a++)
         if (hist[a].wba == src && int'(tuse) < remain(hist[a], a)) h = 1;
      return h;
   endfunction

   function automatic int fwd_d(input logic [4:0] src);
      if (src == 0) return 0;
      if (hist[0].wba == src && remain(hist[0], 0) == 0) return 2;
      if (hist[1].wba == src && remain(hist[1], 1) == 0) return 1;
      return 0;
   endfunction

   function automatic int fwd_e(input logic [4:0] src);
      if (src == 0) return 0;
      if (hist[1].wba == src && remain(hist[1], 1) == 0) return 2;
      if (hist[2].wba == src) return 1;
      return 0;
   endfunction

   function automatic bit m_busy();
      return (now <= busy_until) || hist[0].md == 2'b01 || hist[0].md == 2'b10;
   endfunction

   function automatic bit m_stall();
      return hz(rs_D, tuse_rs_D) || hz(rt_D, tuse_rt_D) ||
             (md_op_D != 2'b00 && m_busy());
   endfunction

   // Clock edge: update the model from the current inputs, then wait.
   task automatic advance();
      ins_t nw;
      if (reset) begin
         for (int i = 0; i < 3; i++) hist[i] = '0;
         busy_until = -1;
      end else begin
         if (hist[0].md == 2'b01) busy_until = now + MC;
         if (hist[0].md == 2'b10) busy_until = now + DC;
         nw = m_stall() ? '0 : '{rs: rs_D, rt: rt_D, wba: wba_D, tnew: tnew_D, md: md_op_D};
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = nw;
      end
      now++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] trs, input logic [1:0] trt,
                        input logic [4:0] wba, input logic [1:0] tnew,
                        input logic [1:0] md);
      rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
      wba_D = wba; tnew_D = tnew; md_op_D = md;
   endtask

   task automatic nop();
      set_d(0, 0, 3, 3, 0, 0, 0);
   endtask

   task automatic do_reset();
      nop();
      reset = 1'b1;
      advance();
      reset = 1'b0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_stall"},    stall,    m_stall());
      chk({tag, "_clrE"},     clr_E,    m_stall());
      chk({tag, "_busy"},     md_busy,  m_busy());
      chk({tag, "_fwdrsD"},   fwd_rs_D, fwd_d(rs_D));
      chk({tag, "_fwdrtD"},   fwd_rt_D, fwd_d(rt_D));
      chk({tag, "_fwdrsE"},   fwd_rs_E, fwd_e(hist[0].rs));
      chk({tag, "_fwdrtE"},   fwd_rt_E, fwd_e(hist[0].rt));
      chk({tag, "_fwdrtM"},   fwd_rt_M,
          (hist[1].rt != 0 && hist[1].rt == hist[2].wba) ? 1 : 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [4:0] rs;
      logic [1:0] tuse;
      logic [4:0] wba;
      logic [1:0] tnew;
      logic       e_stall;
      logic [1:0] e_fd;
      logic [1:0] e_fe;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input logic [4:0] rs, input logic [1:0] tuse,
                               input logic [4:0] wba, input logic [1:0] tnew,
                               input logic st, input logic [1:0] fd,
                               input logic [1:0] fe);
      vec_t v;
      v.rs = rs; v.tuse = tuse; v.wba = wba; v.tnew = tnew;
      v.e_stall = st; v.e_fd = fd; v.e_fe = fe;
      return v;
   endfunction

   initial begin
      int len;
      logic prev_busy;

      //            rs  tuse wba tnew stall fD fE
      tbl[0]  = mk(0,  3,  0,  0,  0,  0, 0);  // reset state
      tbl[1]  = mk(0,  3,  8,  1,  0,  0, 0);  // ALU writes $8
      tbl[2]  = mk(8,  1,  0,  0,  0,  0, 0);  // consumer, no stall
      tbl[3]  = mk(0,  3,  0,  0,  0,  0, 2);  // consumer in E gets M value
      tbl[4]  = mk(0,  3,  9,  2,  0,  0, 0);  // lw $9
      tbl[5]  = mk(9,  0,  0,  0,  1,  0, 0);  // beq: stall 1
      tbl[6]  = mk(9,  0,  0,  0,  1,  0, 0);  // beq: stall 2
      tbl[7]  = mk(9,  0,  0,  0,  0,  0, 0);  // released, from GRF
      tbl[8]  = mk(0,  3, 31,  0,  0,  0, 0);  // jal
      tbl[9]  = mk(31, 0,  0,  0,  0,  2, 0);  // jr: forward from E
      tbl[10] = mk(0,  3,  0,  2,  0,  0, 2);  // write to $0; jr in E from M
      tbl[11] = mk(0,  0,  0,  0,  0,  0, 0);  // read $0: nothing

      for (int i = 0; i < 3; i++) hist[i] = '0;
      do_reset();

      for (int i = 0; i < 12; i++) begin
         set_d(tbl[i].rs, 0, tbl[i].tuse, 3, tbl[i].wba, tbl[i].tnew, 0);
         #2;
         chk($sformatf("tbl%0d_stall", i),  stall,    tbl[i].e_stall);
         chk($sformatf("tbl%0d_clrE", i),   clr_E,    tbl[i].e_stall);
         chk($sformatf("tbl%0d_fwdrsD", i), fwd_rs_D, tbl[i].e_fd);
         chk($sformatf("tbl%0d_fwdrsE", i), fwd_rs_E, tbl[i].e_fe);
         chk($sformatf("tbl%0d_busy", i),   md_busy,  0);
         chk($sformatf("tbl%0d_fwdrt", i),
             int'(fwd_rt_D) + int'(fwd_rt_E) + int'(fwd_rt_M), 0);
         advance();
      end

      // ---------------- mult / div then mfhi ----------------
      for (int k = 0; k < 2; k++) begin
         do_reset();
         set_d(0, 0, 3, 3, 0, 0, (k == 0) ? 2'b01 : 2'b10);
         advance();
         set_d(0, 0, 3, 3, 0, 0, 2'b11);
         len = 0;
         prev_busy = 1'b0;
         for (int c = 0; c < 40; c++) begin
            #2;
            if (!stall) break;
            len++;
            prev_busy = md_busy;
            advance();
         end
         chk(k == 0 ? "mult_stall_len" : "div_stall_len", len,
             (k == 0 ? MC : DC) + 1);
         chk(k == 0 ? "mult_busy_fall" : "div_busy_fall", md_busy, 0);
         chk(k == 0 ? "mult_busy_before" : "div_busy_before", prev_busy, 1);
         advance();
      end

      // ---------------- reset during div ----------------
      do_reset();
      set_d(0, 0, 3, 3, 0, 0, 2'b10);
      advance();
      nop();
      advance();
      advance();
      #2;
      chk("rst_div_busy_before", md_busy, 1);
      reset = 1'b1;
      advance();
      reset = 1'b0;
      set_d(0, 0, 3, 3, 0, 0, 2'b11);
      #2;
      chk("rst_div_busy", md_busy, 0);
      chk("rst_div_stall", stall, 0);
      advance();

      // ---------------- randomized traffic ----------------
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
               ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3)));
         #2;
         check_model($sformatf("rnd%0d", i));
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
